// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit saturating direction counters, combinational lookup, registered mispredict
module branch_target_buffer #(
  parameter int PC_W  = 10,
  parameter int IDX_W = 4,
  parameter int TAG_W = PC_W - IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] pc_F,
  output logic            prediction_F,
  output logic            hit_F,
  output logic [PC_W-1:0] target_F,
  output logic [1:0]      state_F,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target,
  output logic            mispredict
);
  localparam int N = 2 ** IDX_W;
  logic            v  [N];
  logic [TAG_W-1:0] tg [N];
  logic [PC_W-1:0] tt [N];
  logic [1:0]      ct [N];
  logic [IDX_W-1:0] fi, ui;
  logic [TAG_W-1:0] ut;
  logic            uh, up;
  logic [1:0]      nc;
  always_comb begin
    fi           = pc_F[IDX_W-1:0];
    hit_F        = v[fi] && tg[fi] == pc_F[PC_W-1:IDX_W];
    prediction_F = hit_F && ct[fi][1];
    target_F     = hit_F ? tt[fi] : '0;
    state_F      = hit_F ? ct[fi] : 2'b01;
    ui           = upd_pc[IDX_W-1:0];
    ut           = upd_pc[PC_W-1:IDX_W];
    uh           = v[ui] && tg[ui] == ut;
    up           = uh && ct[ui][1];
    nc           = !uh ? (upd_taken ? 2'b10 : 2'b01) :
                   upd_taken ? (ct[ui] == 2'b11 ? 2'b11 : ct[ui] + 2'b01) :
                               (ct[ui] == 2'b00 ? 2'b00 : ct[ui] - 2'b01);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        v[i]  <= 1'b0;
        tg[i] <= '0;
        tt[i] <= '0;
        ct[i] <= '0;
      end
      mispredict <= 1'b0;
    end else begin
      mispredict <= upd_en && (up != upd_taken || (upd_taken && up && tt[ui] != upd_target));
      if (upd_en) begin
        v[ui]  <= 1'b1;
        tg[ui] <= ut;
        ct[ui] <= nc;
        if (upd_taken || !uh) tt[ui] <= upd_target;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed plan steps plus random traffic against a table-of-branches reference model
module tb_branch_target_buffer;
  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] pc_F, upd_pc, upd_target, target_F;
  logic       prediction_F, hit_F, upd_en, upd_taken, mispredict;
  logic [1:0] state_F;
  int vecs = 0;
  int errs = 0;
  bit         mv [16];
  logic [9:0] mpc [16];
  logic [9:0] mtg [16];
  int         mc [16];

  branch_target_buffer dut (
    .clk(clk), .rst(rst), .pc_F(pc_F), .prediction_F(prediction_F), .hit_F(hit_F),
    .target_F(target_F), .state_F(state_F), .upd_en(upd_en), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mhit(input logic [9:0] p);
    return mv[p % 16] && (mpc[p % 16] / 16) == (p / 16);
  endfunction

  task automatic mclear();
    for (int i = 0; i < 16; i++) begin
      mv[i] = 0; mpc[i] = '0; mtg[i] = '0; mc[i] = 0;
    end
  endtask

  task automatic step(input logic [9:0] p, input logic e, input logic [9:0] up,
                      input logic t, input logic [9:0] ut, input logic r, input string tag);
    bit h, pr, mexp;
    int i;
    pc_F = p; upd_en = e; upd_pc = up; upd_taken = t; upd_target = ut; rst = r;
    #1;
    h = mhit(p);
    i = p % 16;
    chk({tag, "_lookup"}, {18'd0, prediction_F, hit_F, target_F, state_F},
        {18'd0, h && mc[i] >= 2, h, h ? mtg[i] : 10'd0, h ? 2'(mc[i]) : 2'b01});
    mexp = 0;
    if (r) mclear();
    else if (e) begin
      i = up % 16;
      h = mhit(up);
      pr = h && mc[i] >= 2;
      mexp = (pr != t) || (t && pr && mtg[i] != ut);
      if (h) begin
        mc[i] = t ? (mc[i] == 3 ? 3 : mc[i] + 1) : (mc[i] == 0 ? 0 : mc[i] - 1);
        if (t) mtg[i] = ut;
      end else begin
        mv[i] = 1; mpc[i] = up; mtg[i] = ut; mc[i] = t ? 2 : 1;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, mexp});
  endtask

  initial begin
    pc_F = '0; upd_en = 0; upd_pc = '0; upd_taken = 0; upd_target = '0; rst = 1;
    @(posedge clk);
    #1;
    mclear();
    rst = 0;
    step(10'h013, 0, 10'h000, 0, 10'h000, 0, "reset_miss");
    chk("reset_state_const", {22'd0, prediction_F, hit_F, target_F, state_F}, {22'd0, 2'b00, 10'h000, 2'b01});
    step(10'h013, 1, 10'h013, 1, 10'h040, 0, "install");
    chk("install_mispredict_const", {31'd0, mispredict}, 32'd1);
    step(10'h013, 0, 10'h000, 0, 10'h000, 0, "installed");
    chk("installed_const", {22'd0, prediction_F, hit_F, target_F, state_F}, {22'd0, 2'b11, 10'h040, 2'b10});
    for (int k = 0; k < 4; k++) step(10'h013, 1, 10'h013, 1, 10'h040, 0, "taken_sat");
    chk("saturate_const", {30'd0, state_F}, 32'd3);
    for (int k = 0; k < 3; k++) step(10'h013, 1, 10'h013, 0, 10'h123, 0, "not_taken");
    step(10'h013, 0, 10'h000, 0, 10'h000, 0, "after_nt");
    chk("strong_nt_const", {22'd0, prediction_F, hit_F, target_F, state_F}, {22'd0, 2'b01, 10'h040, 2'b00});
    step(10'h013, 1, 10'h013, 1, 10'h040, 0, "alias_install");
    step(10'h013, 1, 10'h023, 0, 10'h077, 0, "alias_evict");
    step(10'h013, 0, 10'h000, 0, 10'h000, 0, "alias_old");
    step(10'h023, 0, 10'h000, 0, 10'h000, 0, "alias_new");
    step(10'h055, 1, 10'h055, 1, 10'h111, 0, "nobypass_same");
    step(10'h055, 0, 10'h000, 0, 10'h000, 0, "nobypass_next");
    chk("nobypass_hit_const", {31'd0, hit_F}, 32'd1);
    step(10'h013, 1, 10'h013, 1, 10'h040, 0, "populate");
    step(10'h013, 1, 10'h066, 1, 10'h200, 1, "rst_upd");
    chk("rst_mispredict_const", {31'd0, mispredict}, 32'd0);
    step(10'h013, 0, 10'h000, 0, 10'h000, 0, "post_rst_013");
    step(10'h066, 0, 10'h000, 0, 10'h000, 0, "post_rst_066");
    step(10'h055, 0, 10'h000, 0, 10'h000, 0, "post_rst_055");
    for (int k = 0; k < 400; k++) begin
      logic [9:0] p, up, ut;
      p  = {8'($urandom_range(0, 3)), 2'($urandom)} ^ 10'h000;
      p  = {2'b00, 4'($urandom_range(0, 3)), 4'($urandom)};
      up = {2'b00, 4'($urandom_range(0, 3)), 4'($urandom)};
      ut = ($urandom_range(0, 1) != 0) ? 10'($urandom) : 10'h040;
      step(p, $urandom_range(0, 9) < 8, up, 1'($urandom), ut, $urandom_range(0, 99) < 2, "random");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch side: looked up combinationally with the current fetch PC. Supplies the predicted-taken flag, target address and counter state that travel down IF/ID and ID/EX with the instruction.
- Execute side: updated synchronously when a conditional branch (beq/bne) resolves in EX.
- Sits beside the fetch stage, feeding the next-PC mux, and consumes the resolution results from the execute stage.

Parameters:
- PC_W, 10, width of instruction address (word-addressed PC).
- IDX_W, 4, index bits; table depth = 2**IDX_W entries.
- TAG_W, PC_W-IDX_W, tag bits stored per entry (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_F  in  PC_W  current fetch PC (lookup address).
- prediction_F  out  1  predict taken: entry hit AND counter[1]==1.
- hit_F  out  1  valid entry with matching tag at pc_F.
- target_F  out  PC_W  stored target of hit entry; 0 on miss.
- state_F  out  2  counter of hit entry; 2'b01 on miss.
- upd_en  in  1  branch resolved in EX this cycle (Branch_EX, ID/EX not flushed).
- upd_pc  in  PC_W  PC of the resolving branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual branch target computed in EX.
- mispredict  out  1  registered; 1 for one cycle after an update whose outcome or target disagreed with the table state at update time.

Behaviour:
- Storage per entry:
  - valid (1b), tag (TAG_W), target (PC_W), ctr (2b).
  - Held in flip-flops, not block RAM.
  - index = pc[IDX_W-1:0], tag = pc[PC_W-1:IDX_W].
- Reset:
  - While rst=1 at a clock edge, every valid bit goes to 0. Tags, targets and counters also go to 0.
  - mispredict goes to 0.
  - After reset, the lookup outputs are therefore miss values: prediction_F=0, hit_F=0, target_F=0, state_F=2'b01.
  - An update presented while rst=1 is discarded.
- Lookup:
  - Purely combinational from pc_F and the current table contents. Zero latency.
  - No bypass: if an update writes the same index in the same cycle, the lookup returns pre-update contents. The new contents are visible from the next cycle.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  - Taken increments, saturating at 11.
  - Not-taken decrements, saturating at 00.
- Update (rising edge with upd_en=1, rst=0):
  - Hit (valid and tag match at upd index):
    - ctr saturates up or down per upd_taken.
    - If upd_taken=1, target is overwritten with upd_target. If not taken, target is unchanged.
  - Miss:
    - Entry is replaced: valid=1, tag=upd tag, target=upd_target.
    - ctr = upd_taken ? 10 : 01.
    - The old entry is lost (no victim handling).
- mispredict:
  - Next-cycle value = upd_en & ~rst & (predicted != upd_taken | (upd_taken & predicted & stored target != upd_target)).
  - predicted = hit & ctr[1], evaluated on the table contents before the edge.
  - Otherwise mispredict is 0.
  - Mispredict is informational only; the hazard unit keeps its own flush logic.
- Aliasing: two branches sharing an index evict each other. No way associativity.
- Indirect jumps (jr) and direct jumps must never drive upd_en. The block does not check this.
- Simultaneous lookup and update of the same PC is legal. See the no-bypass rule above.

Test Plan:
1. Reset, then pc_F=10'h013 -> prediction_F=0, hit_F=0, target_F=0, state_F=01.
2. Update upd_pc=0x013, taken=1, target=0x040; next cycle pc_F=0x013 -> hit_F=1, prediction_F=1, target_F=0x040, state_F=10; mispredict=1 for one cycle.
3. Four more taken updates of 0x013 -> state_F saturates at 11. Then three not-taken updates -> 10, 01, 00; prediction_F=0 from the second not-taken onward; target_F stays 0x040.
4. Alias: install 0x013 (taken), then update 0x023 (same index 3, not taken) -> pc_F=0x013 misses; pc_F=0x023 hits with state 01, prediction_F=0.
5. Same-cycle update and lookup of 0x055 on an empty table -> hit_F=0 in that cycle, hit_F=1 in the following cycle.
6. Populate 0x013, assert rst for one cycle together with upd_en -> all lookups miss afterwards; mispredict=0; the discarded update leaves no entry.
